// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encodings and default word width for the hash_speed serial adder
package serial_add_ctrl_pkg;
  localparam int HS_WORD_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder (a + b + c -> s, carry)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic carry
);
  assign s     = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial (LSB first) WIDTH-bit adder with start/busy/done handshake and accumulate mode
// Ports: clk, rst_n (async active-low); start/acc/op_a/op_b/cin request an addition (acc=1 reuses sum as A);
// busy high while bits are processed; done pulses one cycle when sum/cout are valid; sum/cout held until next start.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = HS_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             acc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, res;
  logic [WIDTH-2:0] r_q;
  logic             c_q, busy_q, done_q, cout_q, fa_s, fa_c, accept, last;
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .c(c_q), .s(fa_s), .carry(fa_c));
  // r_q holds the WIDTH-1 bits already produced; res is the full word once the top bit arrives
  always_comb begin
    accept  = start && state_q != ST_RUN;
    last    = cnt_q == CNT_W'(WIDTH - 1);
    res     = {fa_s, r_q};
    state_d = accept ? ST_RUN : state_q == ST_RUN ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d == ST_RUN;
      done_q  <= state_d == ST_DONE;
      if (accept) begin
        a_q   <= acc ? sum_q : op_a;
        b_q   <= op_b;
        c_q   <= cin;
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        r_q   <= res[WIDTH-1:1];
        c_q   <= fa_c;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          sum_q  <= res;
          cout_q <= fa_c;
        end
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH 8, 16 and 32
module tb_serial_add_ctrl;
  localparam int WD[3] = '{8, 16, 32};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [2:0]  st, ac, ci;
  logic [31:0] opa [3];
  logic [31:0] opb [3];
  logic        bz8, bz16, bz32, dn8, dn16, dn32, co8, co16, co32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [2:0]  bz, dn, co;
  logic [31:0] sm [3];
  assign bz = {bz32, bz16, bz8};
  assign dn = {dn32, dn16, dn8};
  assign co = {co32, co16, co8};
  always_comb begin
    sm[0] = {24'd0, s8};
    sm[1] = {16'd0, s16};
    sm[2] = s32;
  end
  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .acc(ac[0]), .op_a(opa[0][7:0]), .op_b(opb[0][7:0]),
    .cin(ci[0]), .busy(bz8), .done(dn8), .sum(s8), .cout(co8));
  serial_add_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .acc(ac[1]), .op_a(opa[1][15:0]), .op_b(opb[1][15:0]),
    .cin(ci[1]), .busy(bz16), .done(dn16), .sum(s16), .cout(co16));
  serial_add_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .acc(ac[2]), .op_a(opa[2]), .op_b(opb[2]),
    .cin(ci[2]), .busy(bz32), .done(dn32), .sum(s32), .cout(co32));
  typedef struct {
    int          k;
    logic [32:0] v;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          issued [3];
  int          dones [3];
  logic [32:0] hold [3];
  logic [31:0] msum [3];
  function automatic logic [32:0] ref_add(int k, logic [31:0] a, logic [31:0] b, logic c);
    longint m = (longint'(1) << WD[k]) - 1;
    longint t = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return {1'(t >> WD[k]), 32'(t & m)};
  endfunction
  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask
  task automatic wait_free(int k);
    int n = 0;
    while (bz[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bz[k]) timeout("wait_free");
  endtask
  task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic c, logic acc_b);
    logic [32:0] r;
    wait_free(k);
    opa[k] = a;
    opb[k] = b;
    ci[k]  = c;
    ac[k]  = acc_b;
    st[k]  = 1'b1;
    r = ref_add(k, acc_b ? msum[k] : a, b, c);
    msum[k] = r[31:0];
    sb.push_back('{k, r});
    issued[k]++;
    @(posedge clk);
    #1 st[k] = 1'b0;
  endtask
  task automatic wait_done(int k, logic [32:0] e, string name);
    int n = 0;
    while (!dn[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dn[k]) timeout(name);
    else chk(name, {co[k], sm[k]}, e);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (dn[k]) begin
          int idx;
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i].k == k) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst=%0d actual=%h", k, {co[k], sm[k]});
          end else begin
            chk("scoreboard", {co[k], sm[k]}, sb[idx].v);
            hold[k] = sb[idx].v;
            sb.delete(idx);
          end
          dones[k]++;
        end
        if (bz[k]) chk("held_while_busy", {co[k], sm[k]}, hold[k]);
        if (bz[k] && dn[k]) chk("busy_done_excl", {31'd0, bz[k], dn[k]}, 33'd0);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    st = '0;
    ac = '0;
    ci = '0;
    for (int k = 0; k < 3; k++) begin
      opa[k] = '0;
      opb[k] = '0;
      hold[k] = '0;
      msum[k] = '0;
      issued[k] = 0;
      dones[k] = 0;
    end
    #2 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out", {co[k], sm[k]}, 33'd0);
      chk("reset_flags", {31'd0, dn[k], bz[k]}, 33'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'h35, 32'h4A, 1'b0, 1'b0);
    @(negedge clk);
    n = 0;
    while (bz[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 8);
    wait_done(0, {1'b0, 32'h7F}, "add_35_4a");
    issue(0, 32'hFF, 32'h00, 1'b1, 1'b0);
    wait_done(0, {1'b1, 32'h00}, "ripple_ff");
    issue(2, 32'h6A09E667, 32'hBB67AE85, 1'b0, 1'b0);
    wait_done(2, {1'b1, 32'h257194EC}, "chain_first");
    issue(2, 32'hDEADBEEF, 32'h3C6EF372, 1'b0, 1'b1);
    @(negedge clk);
    chk("chain_no_idle", {32'd0, bz[2]}, 33'd1);
    wait_done(2, {1'b0, 32'h61E0885E}, "chain_second");
    issue(0, 32'h12, 32'h34, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st[0] = 1'b1;
      opa[0] = $urandom;
      opb[0] = $urandom;
      ci[0] = 1'b0;
      @(negedge clk);
      st[0] = 1'b0;
    end
    wait_done(0, {1'b0, 32'h47}, "start_ignored");
    repeat (4) @(negedge clk);
    chk("single_done", dones[0], issued[0]);
    issue(0, 32'hA5, 32'h5A, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {co[0], sm[0]}, 33'd0);
    chk("rst_mid_flags", {31'd0, dn[0], bz[0]}, 33'd0);
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].k == 0) sb.delete(i);
    issued[0]--;
    for (int k = 0; k < 3; k++) begin
      hold[k] = '0;
      msum[k] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'h01, 32'h01, 1'b0, 1'b0);
    wait_done(0, {1'b0, 32'h02}, "after_reset");
    void'($urandom(32'hC0FFEE));
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_free(1);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(1, $urandom, $urandom, 1'($urandom), $urandom_range(0, 2) == 0);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("done_count", dones[k], issued[k]);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
